// File: rtl/cube_root_pkg.sv
// Shared FSM type, 7-segment codes and constant helpers for the
// sequential cube-root display engine.
package cube_root_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROOT,
        ST_BCD,
        ST_COMMIT
    } state_e;

    // Segment order {a,b,c,d,e,f,g,dp}, active low; index = decimal digit.
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'b0000_1001, 8'b0000_0001, 8'b0001_1111, 8'b0100_0001, 8'b0100_1001,
        8'b1001_1001, 8'b0000_1101, 8'b0010_0101, 8'b1001_1111, 8'b0000_0011
    };
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

    // Non-BCD nibble value used to request a dash from the scanner.
    localparam logic [3:0] NIB_DASH = 4'hA;

    function automatic int clog2(input longint unsigned v);
        int n;
        n = 0;
        while ((64'd1 << n) < v) n++;
        return n;
    endfunction

    function automatic longint unsigned pow10(input int e);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/cube_root_seq_display_scan.sv
// Time-multiplexed 7-segment driver: refresh counter, digit select and
// segment decode, with an and seg registered together.
module seven_seg_scan
    import cube_root_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int REFRESH_W = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIGITS-1:0][3:0] nib,
    input  logic [DIGITS-1:0]      blank,
    input  logic [DIGITS-1:0]      dp,
    output logic [DIGITS-1:0]      an,
    output logic [7:0]             seg
);

    localparam int SEL_W = (DIGITS > 1) ? clog2(DIGITS) : 1;

    logic [REFRESH_W-1:0] tick_q, tick_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic [3:0]           cur_nib;
    logic                 cur_blank;
    logic                 cur_dp;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        tick_d    = tick_q + REFRESH_W'(1);
        sel_d     = sel_q;
        an_d      = '1;
        cur_nib   = '0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;

        // The select counts up while digits are visited from the left, wrapping at DIGITS.
        if (&tick_q) begin
            sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q == SEL_W'(DIGITS - 1 - i)) begin
                an_d[i]   = 1'b0;
                cur_nib   = nib[i];
                cur_blank = blank[i];
                cur_dp    = dp[i];
            end
        end

        if (cur_blank)                seg_d = SEG_BLANK;
        else if (cur_nib == NIB_DASH) seg_d = SEG_DASH;
        else if (cur_nib <= 4'd9)     seg_d = SEG_DIGITS[cur_nib];
        else                          seg_d = SEG_BLANK;
        if (cur_dp) seg_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            sel_q  <= '0;
            an_q   <= ~(DIGITS'(1) << (DIGITS - 1));
            seg_q  <= SEG_BLANK;
        end else begin
            tick_q <= tick_d;
            sel_q  <= sel_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: rtl/cube_root_seq_display.sv
// Sequential fixed-point cube root (digit-by-digit), double-dabble BCD
// conversion and a scanned 7-segment readout with blanking and overflow.
module cube_root_seq_display
    import cube_root_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int FRAC_DIGITS = 2,
    parameter int DIGITS      = 4,
    parameter int REFRESH_W   = 18,
    localparam longint unsigned SCALE = pow10(3 * FRAC_DIGITS),
    localparam int X_W   = ((IN_W + clog2(SCALE) + 2) / 3) * 3,
    localparam int R_W   = X_W / 3,
    localparam int BCD_N = (R_W + 2) / 3 + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IN_W-1:0]   number,
    output logic              busy,
    output logic              done,
    output logic [R_W-1:0]    root,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int STEP_W = clog2(R_W + 1);
    localparam logic [X_W-1:0] SCALE_X = X_W'(SCALE);
    localparam logic [X_W+1:0] ONE_W   = (X_W + 2)'(1);
    localparam logic [X_W+1:0] THREE_W = (X_W + 2)'(3);

    state_e                   state_q, state_d;
    logic [X_W-1:0]           x_q, x_d;
    logic [R_W-1:0]           y_q, y_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [BCD_N-1:0][3:0]    bcd_q, bcd_d;
    logic [R_W-1:0]           root_q, root_d;
    logic                     ovf_q, ovf_d;
    logic [DIGITS-1:0][3:0]   nib_q, nib_d;
    logic [DIGITS-1:0]        blank_q, blank_d;
    logic [DIGITS-1:0]        dp_q, dp_d;

    logic [R_W-1:0]           y2;
    logic [X_W+1:0]           y2_w;
    logic [X_W+1:0]           trial;
    int                       shift;
    logic [R_W-1:0]           y_scan;
    logic [BCD_N-1:0][3:0]    adj;
    logic [BCD_N*4-1:0]       adj_flat;
    logic [DIGITS+BCD_N-1:0][3:0] bcd_pad;
    logic                     ovf_c;
    logic                     lead;
    logic [DIGITS-1:0][3:0]   nib_c;
    logic [DIGITS-1:0]        blank_c;
    logic [DIGITS-1:0]        dp_c;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        step_d  = step_q;
        bcd_d   = bcd_q;
        root_d  = root_q;
        ovf_d   = ovf_q;
        nib_d   = nib_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        done    = 1'b0;

        // One root bit per step: trial = (3y(y+1)+1) << s after y doubles.
        y2    = {y_q[R_W-2:0], 1'b0};
        y2_w  = (X_W + 2)'(y2);
        shift = X_W - 3 - 3 * int'(step_q);
        trial = (y2_w * (y2_w + ONE_W) * THREE_W + ONE_W) << shift;

        y_scan = y_q << step_q;
        for (int i = 0; i < BCD_N; i++) begin
            adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
        end
        adj_flat = adj;

        bcd_pad = '0;
        bcd_pad[BCD_N-1:0] = bcd_q;
        ovf_c = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++) begin
            ovf_c = ovf_c | (bcd_q[i] != 4'd0);
        end

        // Blank leading zeros from the left, never at or right of the decimal point.
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead       = lead && (bcd_pad[i] == 4'd0) && (i > FRAC_DIGITS);
            nib_c[i]   = ovf_c ? NIB_DASH : bcd_pad[i];
            blank_c[i] = !ovf_c && lead;
            dp_c[i]    = !ovf_c && (FRAC_DIGITS > 0) && (i == FRAC_DIGITS);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = X_W'(number) * SCALE_X;
                    y_d     = '0;
                    step_d  = '0;
                    bcd_d   = '0;
                    state_d = ST_ROOT;
                end
            end
            ST_ROOT: begin
                if ({2'b00, x_q} >= trial) begin
                    x_d = x_q - trial[X_W-1:0];
                    y_d = y2 + R_W'(1);
                end else begin
                    y_d = y2;
                end
                if (step_q == STEP_W'(R_W - 1)) begin
                    step_d  = '0;
                    state_d = ST_BCD;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_BCD: begin
                bcd_d = {adj_flat[BCD_N*4-2:0], y_scan[R_W-1]};
                if (step_q == STEP_W'(R_W - 1)) begin
                    step_d  = '0;
                    state_d = ST_COMMIT;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_COMMIT: begin
                root_d  = y_q;
                ovf_d   = ovf_c;
                nib_d   = nib_c;
                blank_d = blank_c;
                dp_d    = dp_c;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            root_q  <= '0;
            ovf_q   <= 1'b0;
            nib_q   <= '0;
            blank_q <= '1;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            root_q  <= root_d;
            ovf_q   <= ovf_d;
            nib_q   <= nib_d;
            blank_q <= blank_d;
            dp_q    <= dp_d;
        end
    end

    // NOTE: working registers are fully loaded on every accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        step_q <= step_d;
        bcd_q  <= bcd_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign root = root_q;
    assign ovf  = ovf_q;

    seven_seg_scan #(
        .DIGITS    (DIGITS),
        .REFRESH_W (REFRESH_W)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .nib   (nib_q),
        .blank (blank_q),
        .dp    (dp_q),
        .an    (an),
        .seg   (seg)
    );

endmodule

// File: tb/tb_cube_root_seq_display.sv
// Self-checking bench: integer cube-root and decimal-display model against
// two configurations of the engine (default width, and an overflowing one).
module tb_cube_root_seq_display;

    localparam int DIG   = 4;
    localparam int FRAC  = 2;
    localparam int R_W   = 10;
    localparam int DIG3  = 3;
    localparam int FRAC3 = 3;
    localparam int R_W3  = 13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, start3 = 1'b0;
    logic [7:0] number = '0, number3 = '0;

    logic busy, done, ovf;
    logic [R_W-1:0] root;
    logic [DIG-1:0] an;
    logic [7:0] seg;

    logic busy3, done3, ovf3;
    logic [R_W3-1:0] root3;
    logic [DIG3-1:0] an3;
    logic [7:0] seg3;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    cube_root_seq_display #(
        .IN_W(8), .FRAC_DIGITS(FRAC), .DIGITS(DIG), .REFRESH_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .number(number),
        .busy(busy), .done(done), .root(root), .ovf(ovf), .an(an), .seg(seg)
    );

    cube_root_seq_display #(
        .IN_W(8), .FRAC_DIGITS(FRAC3), .DIGITS(DIG3), .REFRESH_W(2)
    ) dut3 (
        .clk(clk), .reset(reset), .start(start3), .number(number3),
        .busy(busy3), .done(done3), .root(root3), .ovf(ovf3), .an(an3), .seg(seg3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint icbrt(input longint v);
        longint r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input int d);
        case (d)
            0: return 8'b0000_0011;
            1: return 8'b1001_1111;
            2: return 8'b0010_0101;
            3: return 8'b0000_1101;
            4: return 8'b1001_1001;
            5: return 8'b0100_1001;
            6: return 8'b0100_0001;
            7: return 8'b0001_1111;
            8: return 8'b0000_0001;
            9: return 8'b0000_1001;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected pattern of display position i for value r (r < 0 means blank display).
    function automatic logic [7:0] exp_seg(input longint r, input int i, input int frac, input int ndig);
        longint p;
        longint lim;
        logic [7:0] s;
        p = 1;
        lim = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        for (int k = 0; k < ndig; k++) lim = lim * 10;
        if (r < 0) return 8'hFF;
        if (r >= lim) return 8'b1111_1101;
        if (i > frac && r < p) return 8'hFF;
        s = seg_code(int'((r / p) % 10));
        if (frac > 0 && i == frac) s[0] = 1'b0;
        return s;
    endfunction

    task automatic check_display(input int which, input longint r, input string tag);
        logic [7:0] got [4];
        logic [3:0] an_w;
        logic [7:0] seg_w;
        int ndig;
        int frac;
        ndig = (which == 0) ? DIG : DIG3;
        frac = (which == 0) ? FRAC : FRAC3;
        for (int i = 0; i < 4; i++) got[i] = 'x;
        for (int c = 0; c < 4 * ndig + 4; c++) begin
            @(negedge clk);
            an_w  = (which == 0) ? an : {1'b1, an3};
            seg_w = (which == 0) ? seg : seg3;
            for (int i = 0; i < ndig; i++) begin
                if (an_w == ~(4'(1) << i)) got[i] = seg_w;
            end
        end
        for (int i = 0; i < ndig; i++) begin
            check($sformatf("%s_dig%0d", tag, i), 64'(got[i]), 64'(exp_seg(r, i, frac, ndig)));
        end
    endtask

    // Ends on the negedge after the done cycle, where a new start may be driven.
    task automatic run_op(input logic [7:0] n, input bit hammer, input string tag);
        longint r_exp;
        int lat;
        int dc0;
        r_exp = icbrt(longint'(n) * 1000000);
        dc0 = done_cnt;
        number = n;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (hammer) number = 8'($urandom);
            else start = 1'b0;
        end while (!done && lat < 60);
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(2 * R_W + 1));
        @(negedge clk);
        check({tag, "_root"}, 64'(root), 64'(r_exp));
        check({tag, "_ovf"}, 64'(ovf), 64'(r_exp >= 10000));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_dones"}, 64'(done_cnt - dc0), 64'd1);
    endtask

    initial begin
        logic [7:0] n;
        logic [DIG-1:0] prev;
        int run;
        bit seen_change;
        int dc0;
        int lat;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_root", 64'(root), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_an", 64'(an), 64'(4'b0111));
        check("rst_seg", 64'(seg), 64'hFF);
        check("rst_an3", 64'(an3), 64'(3'b011));
        reset = 1'b0;

        run_op(8'd8, 1'b0, "n8");
        check_display(0, 200, "disp8");
        run_op(8'd255, 1'b0, "n255");
        check_display(0, 634, "disp255");
        run_op(8'd0, 1'b0, "n0");
        check_display(0, 0, "disp0");

        // start held high with changing operands while busy
        run_op(8'd8, 1'b1, "hammer");
        dc0 = done_cnt;
        repeat (5) @(negedge clk);
        check("hammer_no_extra_done", 64'(done_cnt - dc0), 64'd0);
        check("hammer_root", 64'(root), 64'd200);

        // reset in cycle 10 of a computation
        dc0 = done_cnt;
        number = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        check("abort_root", 64'(root), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        repeat (30) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
        check_display(0, -1, "abort_disp");
        run_op(8'd200, 1'b0, "after_abort");
        check_display(0, icbrt(200 * 1000000), "after_abort_disp");

        // randomized operands, back to back where no display check intervenes
        for (int k = 0; k < 12; k++) begin
            n = 8'($urandom);
            run_op(n, 1'($urandom), $sformatf("rnd%0d_n%0d", k, n));
            if (k % 3 == 0) check_display(0, icbrt(longint'(n) * 1000000), $sformatf("rnd%0d_disp", k));
        end

        // scan order, hold length and single active anode
        prev = an;
        run = 1;
        seen_change = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("scan_onehot", 64'($countones(~an)), 64'd1);
            if (an == prev) begin
                run++;
            end else begin
                if (seen_change) check("scan_hold", 64'(run), 64'd4);
                check("scan_next", 64'(an), 64'({prev[0], prev[DIG-1:1]}));
                seen_change = 1'b1;
                run = 1;
                prev = an;
            end
        end

        // overflowing configuration
        number3 = 8'd255;
        start3 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start3 = 1'b0;
        end while (!done3 && lat < 60);
        check("ovf_latency", 64'(lat), 64'(2 * R_W3 + 1));
        @(negedge clk);
        check("ovf_root", 64'(root3), 64'(icbrt(255 * 64'd1000000000)));
        check("ovf_flag", 64'(ovf3), 64'd1);
        check_display(1, icbrt(255 * 64'd1000000000), "ovf_disp");

        number3 = 8'd0;
        start3 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start3 = 1'b0;
        end while (!done3 && lat < 60);
        check("zero3_latency", 64'(lat), 64'(2 * R_W3 + 1));
        @(negedge clk);
        check("zero3_root", 64'(root3), 64'd0);
        check("zero3_ovf", 64'(ovf3), 64'd0);
        check_display(1, 0, "zero3_disp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
